// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: Memory-stage data responder with a posted-store FIFO.
// Define DMEM_COMMIT_TRACE_EN to add the registered Commit* trace outputs.
module dmem_store_buffer #(
   parameter int AW       = 10,
   parameter int SB_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      MemWriteM,
   input  logic                      MemReadM,
   input  logic [31:0]               ALUResultM,
   input  logic [31:0]               WriteDataM,
   output logic [31:0]               ReadDataM,
   output logic                      MisalignM,
   output logic [$clog2(SB_DEPTH):0] BufCount,
   output logic                      BufEmpty
`ifdef DMEM_COMMIT_TRACE_EN
  ,output logic                      CommitValid,
   output logic [31:0]               CommitAddr,
   output logic [31:0]               CommitData
`endif
);

   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = 1 << AW;

   logic [AW-1:0] idx;
   logic          unused_addr;

   assign idx         = ALUResultM[AW+1:2];
   assign unused_addr = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

   logic [31:0]   mem_q [NW] = '{default: '0};

   logic [AW-1:0] sb_idx_q  [SB_DEPTH];
   logic [31:0]   sb_data_q [SB_DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic          enq;
   logic          drain;
   logic          full;

   assign enq   = MemWriteM;
   assign full  = (count_q == CW'(SB_DEPTH));
   // A full buffer always drains, so a store while full never overflows.
   assign drain = (count_q != '0) && (!MemReadM || full);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (drain) begin
         head_d = head_q + PW'(1);
      end
      if (enq) begin
         tail_d = tail_q + PW'(1);
      end
      unique case ({enq, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enq) begin
         sb_idx_q[tail_q]  <= idx;
         sb_data_q[tail_q] <= WriteDataM;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && drain) begin
         mem_q[sb_idx_q[head_q]] <= sb_data_q[head_q];
      end
   end

   logic          fwd_hit;
   logic [31:0]   fwd_data;
   logic [PW-1:0] slot;

   // Walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      for (int k = 0; k < SB_DEPTH; k++) begin
         slot = head_q + PW'(k);
         if ((CW'(k) < count_q) && (sb_idx_q[slot] == idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = sb_data_q[slot];
         end
      end
   end

   assign ReadDataM = fwd_hit ? fwd_data : mem_q[idx];
   assign MisalignM = (MemReadM | MemWriteM) & (|ALUResultM[1:0]);
   assign BufCount  = count_q;
   assign BufEmpty  = (count_q == '0);

`ifdef DMEM_COMMIT_TRACE_EN
   logic        cvalid_q;
   logic [31:0] caddr_q;
   logic [31:0] cdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cvalid_q <= 1'b0;
         caddr_q  <= '0;
         cdata_q  <= '0;
      end else begin
         cvalid_q <= drain;
         caddr_q  <= drain ? 32'({sb_idx_q[head_q], 2'b00}) : '0;
         cdata_q  <= drain ? sb_data_q[head_q] : '0;
      end
   end

   assign CommitValid = cvalid_q;
   assign CommitAddr  = caddr_q;
   assign CommitData  = cdata_q;
`endif

endmodule
